// File: rtl/key_pkg.sv
// Shared constants and types for the repeating-key XOR sequencer.
package key_pkg;

    localparam int KEY_W_DEF    = 8;
    localparam int MAX_KEYS_DEF = 8;
    localparam int IDX_W_DEF    = $clog2(MAX_KEYS_DEF);

    typedef logic [KEY_W_DEF-1:0] key_byte_t;
    typedef logic [IDX_W_DEF-1:0] key_idx_t;

endpackage

// File: rtl/key_store.sv
// Key byte register file: one synchronous write port, one asynchronous read port.
module key_store
    import key_pkg::*;
#(
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_KEYS = MAX_KEYS_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        we,
    input  logic [$clog2(MAX_KEYS)-1:0] waddr,
    input  logic [KEY_W-1:0]            wdata,
    input  logic [$clog2(MAX_KEYS)-1:0] raddr,
    output logic [KEY_W-1:0]            rdata
);

    localparam int IDX_W = $clog2(MAX_KEYS);

    logic [KEY_W-1:0]    kmem [MAX_KEYS];
    logic [MAX_KEYS-1:0] slot_we;

    generate
        for (genvar gi = 0; gi < MAX_KEYS; gi++) begin : g_slot_we
            assign slot_we[gi] = we && (waddr == IDX_W'(gi));
        end
    endgenerate

    // Slots must clear on reset so a driven key reads 0 before any load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                kmem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_KEYS; i++) begin
                if (slot_we[i]) begin
                    kmem[i] <= wdata;
                end
            end
        end
    end

    assign rdata = kmem[raddr];

endmodule

// File: rtl/key_sequencer.sv
// Multibyte XOR key store: loads key bytes and length from sysbus, then
// replays the key byte-by-byte onto sysbus with a cyclic read index.
module key_sequencer
    import key_pkg::*;
#(
    parameter int WORD_W   = 10,
    parameter int KEY_W    = KEY_W_DEF,
    parameter int MAX_KEYS = MAX_KEYS_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    inout  wire  [WORD_W-1:0]           sysbus,
    input  logic                        KEY_bus,
    input  logic                        load_KEY,
    input  logic                        set_LEN,
    input  logic                        next_KEY,
    input  logic                        clr_KEY,
    output logic                        key_ready,
    output logic [$clog2(MAX_KEYS)-1:0] key_idx,
    output logic                        key_wrap
);

    localparam int IDX_W = $clog2(MAX_KEYS);
    localparam int LEN_W = IDX_W + 1;

    logic [LEN_W-1:0] len_reg,  len_next;
    logic [IDX_W-1:0] wptr_reg, wptr_next;
    logic [LEN_W-1:0] fill_reg, fill_next;
    logic [IDX_W-1:0] ridx_reg, ridx_next;
    logic             wrap_reg, wrap_next;

    logic             store_we;
    logic [LEN_W-1:0] len_operand;
    logic [KEY_W-1:0] rd_byte;
    logic [WORD_W-1:0] drive_word;
    logic             unused_bus_bits;

    key_store #(
        .KEY_W    (KEY_W),
        .MAX_KEYS (MAX_KEYS)
    ) u_key_store (
        .clock (clock),
        .reset (reset),
        .we    (store_we),
        .waddr (wptr_reg),
        .wdata (sysbus[KEY_W-1:0]),
        .raddr (ridx_reg),
        .rdata (rd_byte)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_reg  <= '0;
            wptr_reg <= '0;
            fill_reg <= '0;
            ridx_reg <= '0;
            wrap_reg <= 1'b0;
        end else begin
            len_reg  <= len_next;
            wptr_reg <= wptr_next;
            fill_reg <= fill_next;
            ridx_reg <= ridx_next;
            wrap_reg <= wrap_next;
        end
    end

    assign len_operand = sysbus[IDX_W:0];
    assign key_ready   = (len_reg != '0) && (fill_reg >= len_reg);

    always_comb begin
        len_next  = len_reg;
        wptr_next = wptr_reg;
        fill_next = fill_reg;
        ridx_next = ridx_reg;
        wrap_next = 1'b0;
        store_we  = 1'b0;

        if (set_LEN) begin
            // A zero length would leave the key permanently unusable, so it becomes 1.
            if (len_operand == '0) begin
                len_next = LEN_W'(1);
            end else if (len_operand > LEN_W'(MAX_KEYS)) begin
                len_next = LEN_W'(MAX_KEYS);
            end else begin
                len_next = len_operand;
            end
            wptr_next = '0;
            fill_next = '0;
            ridx_next = '0;
        end else begin
            if (load_KEY) begin
                store_we  = 1'b1;
                wptr_next = wptr_reg + IDX_W'(1);
                if (fill_reg != LEN_W'(MAX_KEYS)) begin
                    fill_next = fill_reg + LEN_W'(1);
                end
            end

            if (clr_KEY) begin
                ridx_next = '0;
            end else if (next_KEY && key_ready) begin
                if ({1'b0, ridx_reg} == len_reg - LEN_W'(1)) begin
                    ridx_next = '0;
                    wrap_next = 1'b1;
                end else begin
                    ridx_next = ridx_reg + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        drive_word              = '0;
        drive_word[KEY_W-1:0]   = rd_byte;
    end

    assign sysbus = KEY_bus ? drive_word : 'z;

    assign key_idx  = ridx_reg;
    assign key_wrap = wrap_reg;

    assign unused_bus_bits = ^sysbus;

endmodule
